// File: rtl/main_memory_ctrl.sv
// Word-addressed backing store behind the data cache: one request at a time,
// fixed LATENCY busy cycles, full access/busy handshake before the next request.
module main_memory_ctrl #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mainmem_access,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic        mainmem_busy,
  output logic [31:0] dram_data
);

  localparam int unsigned Depth   = 2 ** ADDR_W;
  localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic [31:0]         dram_q, dram_d;
  logic                is_wr_q, is_wr_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         data_q, data_d;
  logic                mem_we;
  logic [31:0]         mem_q [Depth];

  // Byte-offset and high address bits alias by design.
  logic unused_addr;
  assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    dram_d  = dram_q;
    is_wr_d = is_wr_q;
    idx_d   = idx_q;
    data_d  = data_q;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mainmem_access && (we || re)) begin
          idx_d   = addr[ADDR_W+1:2];
          data_d  = wr_data;
          is_wr_d = we;
          busy_d  = 1'b1;
          cnt_d   = CntInit;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          busy_d  = 1'b0;
          state_d = StDone;
          if (is_wr_q) begin
            mem_we = 1'b1;
          end else begin
            dram_d = mem_q[idx_q];
          end
        end
      end
      StDone: begin
        // Wait for the cache to drop access so a held request cannot retrigger.
        if (!mainmem_access) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      dram_q  <= 32'd0;
      is_wr_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      dram_q  <= dram_d;
      is_wr_q <= is_wr_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  // Storage survives reset; a reset mid-access leaves state_q idle so no write commits.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx_q] <= data_q;
    end
  end

  assign mainmem_busy = busy_q;
  assign dram_data    = dram_q;

endmodule
